// File: rtl/cpu_sequencer_if.sv
// Control-unit request / memory handshake bundle between the sequencer and the datapath.
// master: the sequencer (issues strobes); slave: datapath, control unit and memory.
interface cpu_sequencer_if;
  logic [6:0] opcode;
  logic       mem_read_req;
  logic       mem_write_req;
  logic       reg_write_req;
  logic       jump_req;
  logic       mem_ready;
  logic       ifetch_en;
  logic       ir_load;
  logic       mem_read_strobe;
  logic       mem_write_strobe;
  logic       reg_write_strobe;
  logic       pc_advance;
  logic       pc_jump_sel;

  modport master (
    input  opcode, mem_read_req, mem_write_req, reg_write_req, jump_req, mem_ready,
    output ifetch_en, ir_load, mem_read_strobe, mem_write_strobe, reg_write_strobe,
           pc_advance, pc_jump_sel
  );

  modport slave (
    output opcode, mem_read_req, mem_write_req, reg_write_req, jump_req, mem_ready,
    input  ifetch_en, ir_load, mem_read_strobe, mem_write_strobe, reg_write_strobe,
           pc_advance, pc_jump_sel
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer sharing one memory port, with
// run/step control, sticky fault and retire counter. Define SEQ_EBREAK_EN for ebreak breakpoints.
module cpu_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 15,
  parameter int unsigned COUNT_W        = 16
) (
  input  logic               clk_slow,
  input  logic               reset,
  input  logic               run,
  input  logic               step,
  cpu_sequencer_if.master    bus,
  output logic [2:0]         state,
  output logic               busy,
  output logic               fault,
  output logic               bp_hit,
  output logic [COUNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StFetch     = 3'd1,
    StDecode    = 3'd2,
    StExecute   = 3'd3,
    StMemory    = 3'd4,
    StWriteback = 3'd5,
    StHalt      = 3'd6
  } state_e;

  localparam logic [7:0] WaitLast = 8'(TIMEOUT_CYCLES - 1);

  state_e             state_q;
  logic               fault_q;
  logic               step_q;
  logic               step_edge_q;
  logic [7:0]         wait_q;
  logic [COUNT_W-1:0] count_q;
  logic               is_ebreak;
  logic               restart_blocked;
  logic               op_legal;

`ifdef SEQ_EBREAK_EN
  logic bp_hold_q;
  assign is_ebreak       = (bus.opcode == 7'b1110011);
  assign restart_blocked = bp_hold_q;
`else
  assign is_ebreak       = 1'b0;
  assign restart_blocked = 1'b0;
`endif

  always_comb begin
    op_legal = is_ebreak;
    case (bus.opcode)
      7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
      7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111: op_legal = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_slow or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      fault_q     <= 1'b0;
      step_q      <= 1'b0;
      step_edge_q <= 1'b0;
      wait_q      <= '0;
      count_q     <= '0;
`ifdef SEQ_EBREAK_EN
      bp_hold_q   <= 1'b0;
`endif
    end else begin
      step_q      <= step;
      step_edge_q <= step & ~step_q;
      wait_q      <= '0;
      unique case (state_q)
        StIdle: begin
          // The registered step edge lasts one cycle, so a step seen while busy is dropped.
          if ((run && !restart_blocked) || (!run && step_edge_q)) state_q <= StFetch;
        end
        StFetch, StMemory: begin
          if (bus.mem_ready) begin
            state_q <= (state_q == StFetch) ? StDecode : StWriteback;
          end else if (wait_q == WaitLast) begin
            state_q <= StHalt;
            fault_q <= 1'b1;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        StDecode: begin
          if (op_legal) begin
            state_q <= StExecute;
          end else begin
            state_q <= StHalt;
            fault_q <= 1'b1;
          end
        end
        StExecute: begin
          if (bus.mem_read_req && bus.mem_write_req) begin
            state_q <= StHalt;
            fault_q <= 1'b1;
          end else if (bus.mem_read_req || bus.mem_write_req) begin
            state_q <= StMemory;
          end else begin
            state_q <= StWriteback;
          end
        end
        StWriteback: begin
          count_q <= count_q + COUNT_W'(1);
          if (run && !is_ebreak) state_q <= StFetch;
          else                   state_q <= StIdle;
        end
        StHalt: fault_q <= 1'b1;
        default: begin
          state_q <= StHalt;
          fault_q <= 1'b1;
        end
      endcase
`ifdef SEQ_EBREAK_EN
      if (!run || step_edge_q) bp_hold_q <= 1'b0;
      if (state_q == StWriteback && is_ebreak) bp_hold_q <= 1'b1;
`endif
    end
  end

  // Only ir_load sees mem_ready combinationally; memory strobes stay up until the handshake.
  always_comb begin
    bus.ifetch_en        = 1'b0;
    bus.ir_load          = 1'b0;
    bus.mem_read_strobe  = 1'b0;
    bus.mem_write_strobe = 1'b0;
    bus.reg_write_strobe = 1'b0;
    bus.pc_advance       = 1'b0;
    bus.pc_jump_sel      = 1'b0;
    bp_hit               = 1'b0;
    unique case (state_q)
      StFetch: begin
        bus.ifetch_en = 1'b1;
        bus.ir_load   = bus.mem_ready;
      end
      StMemory: begin
        bus.mem_read_strobe  = bus.mem_read_req;
        bus.mem_write_strobe = bus.mem_write_req;
      end
      StWriteback: begin
        bus.reg_write_strobe = bus.reg_write_req & ~is_ebreak;
        bus.pc_advance       = 1'b1;
        bus.pc_jump_sel      = bus.jump_req & ~is_ebreak;
        bp_hit               = is_ebreak;
      end
      default: ;
    endcase
  end

  assign state       = state_q;
  assign busy        = (state_q != StIdle) && (state_q != StHalt);
  assign fault       = fault_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: a cycle-by-cycle vector table for run/load/store traffic
// plus hand-written step, timeout, illegal-opcode, async-reset and ebreak sequences.
module tb_cpu_sequencer;

  localparam logic [6:0] OpAlu    = 7'b0110011;
  localparam logic [6:0] OpLd     = 7'b0000011;
  localparam logic [6:0] OpSt     = 7'b0100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpBad    = 7'b1111111;
  localparam logic [6:0] OpEbreak = 7'b1110011;

  // Flag order: ifetch ir_load mrd mwr rwr pc_adv jsel busy fault bp_hit
  localparam logic [9:0] FIdle  = 10'b0000000000;
  localparam logic [9:0] FFetch = 10'b1100000100;
  localparam logic [9:0] FBusy  = 10'b0000000100;
  localparam logic [9:0] FMemRd = 10'b0010000100;
  localparam logic [9:0] FMemWr = 10'b0001000100;
  localparam logic [9:0] FWbRw  = 10'b0000110100;
  localparam logic [9:0] FWb    = 10'b0000010100;
  localparam logic [9:0] FHalt  = 10'b0000000010;

  typedef struct {
    logic        run;
    logic [6:0]  op;
    logic        rd;
    logic        wr;
    logic        rw;
    logic        jmp;
    logic        rdy;
    logic [2:0]  st;
    logic [9:0]  fl;
    logic [15:0] cnt;
  } vec_t;

  logic        clk_slow = 1'b0;
  logic        reset    = 1'b0;
  logic        run      = 1'b0;
  logic        step     = 1'b0;
  logic [2:0]  state;
  logic        busy;
  logic        fault;
  logic        bp_hit;
  logic [15:0] instr_count;

  cpu_sequencer_if bus ();

  cpu_sequencer #(
    .TIMEOUT_CYCLES(15),
    .COUNT_W       (16)
  ) dut (
    .clk_slow   (clk_slow),
    .reset      (reset),
    .run        (run),
    .step       (step),
    .bus        (bus),
    .state      (state),
    .busy       (busy),
    .fault      (fault),
    .bp_hit     (bp_hit),
    .instr_count(instr_count)
  );

  always #5 clk_slow = ~clk_slow;

  int   n_cmp = 0;
  int   n_err = 0;
  int   seen;
  int   n;
  logic jsel;
  logic rws;
  logic pca;
  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] flags();
    return {bus.ifetch_en, bus.ir_load, bus.mem_read_strobe, bus.mem_write_strobe,
            bus.reg_write_strobe, bus.pc_advance, bus.pc_jump_sel, busy, fault, bp_hit};
  endfunction

  task automatic drive(input logic r, input logic [6:0] op, input logic rd, input logic wr,
                       input logic rw, input logic jmp, input logic rdy);
    run               = r;
    bus.opcode        = op;
    bus.mem_read_req  = rd;
    bus.mem_write_req = wr;
    bus.reg_write_req = rw;
    bus.jump_req      = jmp;
    bus.mem_ready     = rdy;
  endtask

  task automatic cyc();
    @(posedge clk_slow);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step  = 1'b0;
    drive(1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  function automatic void add(input logic r, input logic [6:0] op, input logic rd,
                              input logic wr, input logic rw, input logic jmp, input logic rdy,
                              input logic [2:0] st, input logic [9:0] fl, input logic [15:0] cnt);
    vec_t v;
    v.run = r;  v.op = op;   v.rd = rd; v.wr = wr; v.rw = rw;
    v.jmp = jmp; v.rdy = rdy; v.st = st; v.fl = fl; v.cnt = cnt;
    vq.push_back(v);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    // Free-run ALU x3, then a load with 3 wait cycles, then a store while run drops.
    add(1, OpAlu, 0, 0, 1, 0, 1, 3'd0, FIdle, 16'd0);
    for (int k = 0; k < 3; k++) begin
      add(1, OpAlu, 0, 0, 1, 0, 1, 3'd1, FFetch, 16'(k));
      add(1, OpAlu, 0, 0, 1, 0, 1, 3'd2, FBusy,  16'(k));
      add(1, OpAlu, 0, 0, 1, 0, 1, 3'd3, FBusy,  16'(k));
      add(1, OpAlu, 0, 0, 1, 0, 1, 3'd5, FWbRw,  16'(k));
    end
    add(1, OpLd, 1, 0, 1, 0, 1, 3'd1, FFetch, 16'd3);
    add(1, OpLd, 1, 0, 1, 0, 1, 3'd2, FBusy,  16'd3);
    add(1, OpLd, 1, 0, 1, 0, 1, 3'd3, FBusy,  16'd3);
    add(1, OpLd, 1, 0, 1, 0, 0, 3'd4, FMemRd, 16'd3);
    add(1, OpLd, 1, 0, 1, 0, 0, 3'd4, FMemRd, 16'd3);
    add(1, OpLd, 1, 0, 1, 0, 0, 3'd4, FMemRd, 16'd3);
    add(1, OpLd, 1, 0, 1, 0, 1, 3'd4, FMemRd, 16'd3);
    add(1, OpLd, 1, 0, 1, 0, 1, 3'd5, FWbRw,  16'd3);
    add(1, OpSt, 0, 1, 0, 0, 1, 3'd1, FFetch, 16'd4);
    add(1, OpSt, 0, 1, 0, 0, 1, 3'd2, FBusy,  16'd4);
    add(1, OpSt, 0, 1, 0, 0, 1, 3'd3, FBusy,  16'd4);
    add(1, OpSt, 0, 1, 0, 0, 1, 3'd4, FMemWr, 16'd4);
    add(0, OpSt, 0, 1, 0, 0, 1, 3'd5, FWb,    16'd4);
    add(0, OpSt, 0, 1, 0, 0, 1, 3'd0, FIdle,  16'd5);
    add(0, OpSt, 0, 1, 0, 0, 1, 3'd0, FIdle,  16'd5);

    drive(1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 reset = 1'b1;
    #1;
    check("reset_state", {state, flags()}, {3'd0, FIdle});
    check("reset_count", instr_count, 16'd0);
    cyc();
    reset = 1'b0;

    foreach (vq[i]) begin
      drive(vq[i].run, vq[i].op, vq[i].rd, vq[i].wr, vq[i].rw, vq[i].jmp, vq[i].rdy);
      #1;
      check($sformatf("vec%0d_out", i), {state, flags()}, {vq[i].st, vq[i].fl});
      check($sformatf("vec%0d_cnt", i), instr_count, vq[i].cnt);
      cyc();
    end

    // Single step with a held step level: exactly one jump instruction.
    do_reset();
    drive(1'b0, OpJal, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    step = 1'b1;
    seen = 0; jsel = 1'b0; rws = 1'b0;
    for (int i = 0; i < 14; i++) begin
      cyc();
      if (bus.pc_advance) begin
        seen++;
        jsel = bus.pc_jump_sel;
        rws  = bus.reg_write_strobe;
      end
    end
    check("step_one_instr", seen, 1);
    check("step_jump_sel", jsel, 1'b1);
    check("step_reg_write", rws, 1'b1);
    check("step_back_idle", {state, flags()}, {3'd0, FIdle});
    check("step_count", instr_count, 16'd1);

    // Fetch timeout: 15 cycles in FETCH, then sticky HALT.
    do_reset();
    drive(1'b1, OpAlu, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    n = 0;
    for (int i = 0; i < 40 && state != 3'd6; i++) begin
      cyc();
      if (state == 3'd1) n++;
    end
    check("timeout_fetch_cycles", n, 15);
    check("timeout_halt", {state, flags()}, {3'd6, FHalt});
    bus.mem_ready = 1'b1;
    repeat (3) cyc();
    check("halt_sticky", {state, flags()}, {3'd6, FHalt});
    reset = 1'b1;
    #1;
    check("reset_clears_fault", {state, flags()}, {3'd0, FIdle});
    cyc();
    reset = 1'b0;

    // Illegal opcode: HALT without any writeback.
    do_reset();
    drive(1'b1, OpBad, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (bus.pc_advance || bus.reg_write_strobe) seen++;
    end
    check("illegal_no_wb", seen, 0);
    check("illegal_halt", {state, flags()}, {3'd6, FHalt});
    check("illegal_count", instr_count, 16'd0);

    // Simultaneous read and write request in EXECUTE faults without touching memory.
    do_reset();
    drive(1'b1, OpSt, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (bus.mem_read_strobe || bus.mem_write_strobe) seen++;
    end
    check("rdwr_no_strobe", seen, 0);
    check("rdwr_halt", {state, flags()}, {3'd6, FHalt});

    // Asynchronous reset in the middle of a stalled load.
    do_reset();
    drive(1'b1, OpLd, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 10 && state != 3'd3; i++) cyc();
    bus.mem_ready = 1'b0;
    cyc();
    check("mem_wait_state", {state, flags()}, {3'd4, FMemRd});
    #2 reset = 1'b1;
    #1;
    check("async_reset_mid_mem", {state, flags()}, {3'd0, FIdle});
    check("async_reset_count", instr_count, 16'd0);
    cyc();
    reset = 1'b0;

    // Ebreak opcode.
    do_reset();
    drive(1'b1, OpEbreak, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
`ifdef SEQ_EBREAK_EN
    seen = 0; rws = 1'b1; jsel = 1'b1; pca = 1'b0;
    for (int i = 0; i < 10 && seen == 0; i++) begin
      cyc();
      if (bp_hit) begin
        seen = 1;
        rws  = bus.reg_write_strobe;
        jsel = bus.pc_jump_sel;
        pca  = bus.pc_advance;
      end
    end
    check("ebreak_bp_hit", seen, 1);
    check("ebreak_wb_flags", {rws, jsel, pca}, 3'b001);
    cyc();
    check("ebreak_idle", {state, flags()}, {3'd0, FIdle});
    repeat (3) cyc();
    check("ebreak_held", {state, flags()}, {3'd0, FIdle});
    check("ebreak_count", instr_count, 16'd1);
    run = 1'b0;
    cyc();
    run = 1'b1;
    cyc();
    check("ebreak_resume", state, 3'd1);
`else
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (bp_hit || bus.pc_advance) seen++;
    end
    check("ebreak_illegal_no_wb", seen, 0);
    check("ebreak_illegal_halt", {state, flags()}, {3'd6, FHalt});
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
